// File: rtl/bcd_scan_display_counter.sv
// bcd_scan_display_counter: N-digit up/down BCD counter with a time-multiplexed 7-segment driver.
module bcd_scan_display_counter #(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV = 10000000,
  parameter int SCAN_DIV = 10000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    up_dn,
  input  logic                    clear,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  output logic [4*NUM_DIGITS-1:0] count_bcd,
  output logic                    carry_out,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   digit_sel
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int SW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  logic [PW-1:0] pre;
  logic [SW-1:0] scan_cnt;
  logic [IW-1:0] idx;
  logic [4*NUM_DIGITS-1:0] stepped, clamped;
  logic [3:0] dig, cur;
  logic [6:0] seg_nxt;
  logic ripple, tick, scan_wrap;
  assign tick = en && pre == PW'(TICK_DIV-1);
  assign scan_wrap = scan_cnt == SW'(SCAN_DIV-1);
  assign cur = count_bcd[4*idx +: 4];
  // ripple carries (up) or borrows (down) from digit 0 upward; final ripple marks the wrap
  always_comb begin
    ripple = 1'b1;
    stepped = count_bcd;
    dig = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      dig = count_bcd[4*i +: 4];
      stepped[4*i +: 4] = !ripple ? dig : up_dn ? (dig == 4'd9 ? 4'd0 : dig + 4'd1) : (dig == 4'd0 ? 4'd9 : dig - 4'd1);
      ripple = ripple && dig == (up_dn ? 4'd9 : 4'd0);
    end
  end
  always_comb begin
    clamped = load_value;
    for (int i = 0; i < NUM_DIGITS; i++)
      clamped[4*i +: 4] = load_value[4*i +: 4] > 4'd9 ? 4'd9 : load_value[4*i +: 4];
  end
  always_comb
    case (cur)
      4'd0: seg_nxt = 7'h3F;
      4'd1: seg_nxt = 7'h06;
      4'd2: seg_nxt = 7'h5B;
      4'd3: seg_nxt = 7'h4F;
      4'd4: seg_nxt = 7'h66;
      4'd5: seg_nxt = 7'h6D;
      4'd6: seg_nxt = 7'h7D;
      4'd7: seg_nxt = 7'h07;
      4'd8: seg_nxt = 7'h7F;
      4'd9: seg_nxt = 7'h6F;
      default: seg_nxt = 7'h00;
    endcase
  always_ff @(posedge clk)
    if (!rst_n) begin
      pre <= '0;
      scan_cnt <= '0;
      idx <= '0;
      count_bcd <= '0;
      carry_out <= 1'b0;
      seg <= '0;
      dp <= 1'b0;
      digit_sel <= '0;
    end else begin
      pre <= clear || tick ? '0 : en ? pre + 1'b1 : pre;
      count_bcd <= clear ? '0 : load ? clamped : tick ? stepped : count_bcd;
      carry_out <= !clear && !load && tick && ripple;
      scan_cnt <= scan_wrap ? '0 : scan_cnt + 1'b1;
      idx <= !scan_wrap ? idx : idx == IW'(NUM_DIGITS-1) ? '0 : idx + 1'b1;
      digit_sel <= NUM_DIGITS'(1) << idx;
      seg <= seg_nxt;
      dp <= idx == '0 && !en;
    end
endmodule

// File: tb/tb_bcd_scan_display_counter.sv
// tb_bcd_scan_display_counter: directed checks of counting, load/clear, scanning and reset.
module tb_bcd_scan_display_counter;
  logic clk = 1'b0;
  logic rst_n, en, up_dn, clear, load;
  logic [7:0] load_value, count_bcd;
  logic carry_out, dp;
  logic [6:0] seg;
  logic [1:0] digit_sel;
  int checks = 0;
  int failures = 0;

  bcd_scan_display_counter #(.NUM_DIGITS(2), .TICK_DIV(4), .SCAN_DIV(2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clear(clear), .load(load),
    .load_value(load_value), .count_bcd(count_bcd), .carry_out(carry_out),
    .seg(seg), .dp(dp), .digit_sel(digit_sel)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; en = 1'b0; up_dn = 1'b1; clear = 1'b0; load = 1'b0; load_value = 8'h00;
    step(2);
    checks++; if (count_bcd !== 8'h00) begin failures++; $display("FAIL reset_count got=%h exp=00", count_bcd); end
    checks++; if (seg !== 7'h00 || digit_sel !== 2'b00 || dp !== 1'b0 || carry_out !== 1'b0) begin
      failures++; $display("FAIL reset_outputs got seg=%h sel=%b dp=%b carry=%b exp all 0", seg, digit_sel, dp, carry_out);
    end
  endtask

  task automatic test_count_up;
    rst_n = 1'b1; en = 1'b1; up_dn = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      for (int c = 0; c < 4; c++) begin
        step(1);
        checks++; if (carry_out !== 1'b0 || dp !== 1'b0) begin failures++; $display("FAIL up_carry_dp k=%0d got carry=%b dp=%b exp 0/0", k, carry_out, dp); end
      end
      checks++; if (count_bcd !== 8'(((k / 10) << 4) | (k % 10))) begin
        failures++; $display("FAIL up_count k=%0d got=%h exp=%0d", k, count_bcd, k);
      end
    end
  endtask

  task automatic test_load_wrap_up;
    load = 1'b1; load_value = 8'h98;
    step(1);
    load = 1'b0;
    checks++; if (count_bcd !== 8'h98) begin failures++; $display("FAIL load98 got=%h exp=98", count_bcd); end
    step(3);
    checks++; if (count_bcd !== 8'h99 || carry_out !== 1'b0) begin failures++; $display("FAIL to99 got=%h carry=%b exp=99/0", count_bcd, carry_out); end
    step(4);
    checks++; if (count_bcd !== 8'h00 || carry_out !== 1'b1) begin failures++; $display("FAIL wrap_up got=%h carry=%b exp=00/1", count_bcd, carry_out); end
    step(1);
    checks++; if (carry_out !== 1'b0) begin failures++; $display("FAIL carry_pulse got=%b exp=0", carry_out); end
    step(3);
    checks++; if (count_bcd !== 8'h01) begin failures++; $display("FAIL after_wrap got=%h exp=01", count_bcd); end
  endtask

  task automatic test_down_and_clamp;
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1; up_dn = 1'b0; en = 1'b1;
    step(3);
    checks++; if (count_bcd !== 8'h00) begin failures++; $display("FAIL down_pretick got=%h exp=00", count_bcd); end
    step(1);
    checks++; if (count_bcd !== 8'h99 || carry_out !== 1'b1) begin failures++; $display("FAIL wrap_down got=%h carry=%b exp=99/1", count_bcd, carry_out); end
    load = 1'b1; load_value = 8'hF3; en = 1'b0;
    step(1);
    load = 1'b0;
    checks++; if (count_bcd !== 8'h93 || carry_out !== 1'b0) begin failures++; $display("FAIL clamp got=%h carry=%b exp=93/0", count_bcd, carry_out); end
  endtask

  task automatic test_pause_and_clear;
    for (int i = 0; i < 20; i++) begin
      step(1);
      checks++; if (count_bcd !== 8'h93) begin failures++; $display("FAIL pause_hold i=%0d got=%h exp=93", i, count_bcd); end
      checks++; if ((digit_sel !== 2'b01 && digit_sel !== 2'b10) || dp !== (digit_sel == 2'b01)) begin
        failures++; $display("FAIL pause_dp i=%0d got sel=%b dp=%b exp dp=1 only on sel=01", i, digit_sel, dp);
      end
    end
    clear = 1'b1; load = 1'b1; load_value = 8'h55;
    step(1);
    clear = 1'b0; load = 1'b0;
    checks++; if (count_bcd !== 8'h00 || carry_out !== 1'b0) begin failures++; $display("FAIL clear_over_load got=%h carry=%b exp=00/0", count_bcd, carry_out); end
  endtask

  task automatic test_scan;
    logic [1:0] ds [10];
    int changes = 0;
    load = 1'b1; load_value = 8'h47;
    step(1);
    load = 1'b0;
    step(1);
    for (int i = 0; i < 10; i++) begin
      ds[i] = digit_sel;
      checks++; if ((digit_sel === 2'b01 && seg !== 7'h07) || (digit_sel === 2'b10 && seg !== 7'h66) || (digit_sel !== 2'b01 && digit_sel !== 2'b10)) begin
        failures++; $display("FAIL scan_seg i=%0d got sel=%b seg=%h exp 01->07 10->66", i, digit_sel, seg);
      end
      if (i >= 2) begin
        checks++; if (ds[i] !== ~ds[i-2]) begin failures++; $display("FAIL scan_period i=%0d got=%b exp=%b", i, ds[i], ~ds[i-2]); end
      end
      if (i >= 1 && ds[i] !== ds[i-1]) changes++;
      step(1);
    end
    checks++; if (changes != 4 && changes != 5) begin failures++; $display("FAIL scan_changes got=%0d exp=4or5", changes); end
  endtask

  task automatic test_reset_midcount;
    load = 1'b1; load_value = 8'h35;
    step(1);
    load = 1'b0; en = 1'b1; up_dn = 1'b1;
    step(2);
    checks++; if (count_bcd !== 8'h35) begin failures++; $display("FAIL pre_reset got=%h exp=35", count_bcd); end
    rst_n = 1'b0;
    step(1);
    checks++; if (count_bcd !== 8'h00 || seg !== 7'h00 || digit_sel !== 2'b00 || dp !== 1'b0) begin
      failures++; $display("FAIL midreset got cnt=%h seg=%h sel=%b dp=%b exp 00/00/00/0", count_bcd, seg, digit_sel, dp);
    end
    rst_n = 1'b1;
    step(1);
    checks++; if (digit_sel !== 2'b01 || seg !== 7'h3F) begin failures++; $display("FAIL first_after_reset got sel=%b seg=%h exp=01/3f", digit_sel, seg); end
    step(2);
    checks++; if (count_bcd !== 8'h00) begin failures++; $display("FAIL prescaler_reset got=%h exp=00", count_bcd); end
    step(1);
    checks++; if (count_bcd !== 8'h01) begin failures++; $display("FAIL first_tick got=%h exp=01", count_bcd); end
  endtask

  initial begin
    test_reset;
    test_count_up;
    test_load_wrap_up;
    test_down_and_clamp;
    test_pause_and_clear;
    test_scan;
    test_reset_midcount;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
